// File: rtl/aes_sbox_arbiter.sv
// Shared AES S-box bank time-multiplexed between the round datapath
// (SubBytes, 16 bytes) and the key expansion (SubWord, 4 bytes).

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128;
  logic [7:0] inv;

  // Inverse as x^254 in GF(2^8); maps 0 to 0 as the cipher requires
  always_comb begin
    x2   = gmul(in_byte, in_byte);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)),
                gmul(gmul(x32, x64), x128));
    out_byte = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
  end

endmodule

module aes_sbox_arbiter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_gnt,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_gnt,
  output logic         kw_done,
  output logic [31:0]  kw_out,
  output logic         busy
);

  localparam int N_ST = 16 / LANES;
  localparam int N_KW = 4 / LANES;
  localparam logic [3:0] ST_LAST = 4'(N_ST - 1);
  localparam logic [3:0] KW_LAST = 4'(N_KW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN_ST,
    RUN_KW
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           prio_kw_q, prio_kw_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   res_q, res_d;
  logic [127:0]   st_out_q, st_out_d;
  logic [31:0]    kw_out_q, kw_out_d;
  logic           st_done_q, st_done_d;
  logic           kw_done_q, kw_done_d;
  logic           busy_q, busy_d;
  logic           idle;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];
  logic [3:0] lane_idx [LANES];

  assign idle   = (state_q == IDLE);
  assign st_gnt = rst_n & idle & st_req & (~kw_req | ~prio_kw_q);
  assign kw_gnt = rst_n & idle & kw_req & (~st_req | prio_kw_q);

  // Idle lanes still read the work register, so outputs never glitch
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_idx[j] = 4'(int'(cnt_q) * LANES + j);
      lane_in[j]  = work_q[{4'd15 - lane_idx[j], 3'b000} +: 8];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_bank
    aes_sbox u_sbox (
      .in_byte (lane_in[j]),
      .out_byte(lane_out[j])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_kw_d = prio_kw_q;
    work_d    = work_q;
    res_d     = res_q;
    st_out_d  = st_out_q;
    kw_out_d  = kw_out_q;
    st_done_d = 1'b0;
    kw_done_d = 1'b0;
    if (state_q != IDLE) begin
      for (int j = 0; j < LANES; j++) begin
        res_d[{4'd15 - lane_idx[j], 3'b000} +: 8] = lane_out[j];
      end
      cnt_d = cnt_q + 4'd1;
    end
    case (state_q)
      IDLE: begin
        if (st_gnt) begin
          work_d    = st_in;
          cnt_d     = 4'd0;
          state_d   = RUN_ST;
          prio_kw_d = 1'b1;
        end else if (kw_gnt) begin
          work_d    = {kw_in, 96'h0};
          cnt_d     = 4'd0;
          state_d   = RUN_KW;
          prio_kw_d = 1'b0;
        end
      end
      RUN_ST: begin
        if (cnt_q == ST_LAST) begin
          state_d   = IDLE;
          cnt_d     = 4'd0;
          st_out_d  = res_d;
          st_done_d = 1'b1;
        end
      end
      RUN_KW: begin
        if (cnt_q == KW_LAST) begin
          state_d   = IDLE;
          cnt_d     = 4'd0;
          kw_out_d  = res_d[127:96];
          kw_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      prio_kw_q <= 1'b1;
      work_q    <= '0;
      res_q     <= '0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_kw_q <= prio_kw_d;
      work_q    <= work_d;
      res_q     <= res_d;
      st_out_q  <= st_out_d;
      kw_out_q  <= kw_out_d;
      st_done_q <= st_done_d;
      kw_done_q <= kw_done_d;
      busy_q    <= busy_d;
    end
  end

  assign st_out  = st_out_q;
  assign kw_out  = kw_out_q;
  assign st_done = st_done_q;
  assign kw_done = kw_done_q;
  assign busy    = busy_q;

endmodule
